// File: rtl/mem_arbiter.sv
// Arbiter sharing one backing-memory port between the icache refill port and the dcache port.
// Grants are held for a full read burst or a single write beat, with an idle bubble between grants.
module mem_arbiter #(
    parameter int unsigned BURST_LEN   = 4,
    parameter int unsigned DC_PRIORITY = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ic_req,
    input  logic [31:0] ic_addr,
    output logic [31:0] ic_rdata,
    output logic        ic_ready,
    input  logic        dc_req,
    input  logic        dc_we,
    input  logic [31:0] dc_addr,
    input  logic [31:0] dc_wdata,
    output logic [31:0] dc_rdata,
    output logic        dc_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic        grant_ic,
    output logic        grant_dc
);

    localparam int unsigned CNT_W = $clog2(BURST_LEN);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GNT_IC = 2'd1,
        GNT_DC = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;
    logic               last_dc_q, last_dc_d;
    logic               own_req;
    logic               burst_done;

    // Owner's request and end-of-grant condition for the current beat
    always_comb begin
        own_req    = 1'b0;
        burst_done = 1'b0;
        if (state_q == GNT_IC) begin
            own_req    = ic_req;
            burst_done = mem_ready && (beat_cnt_q == CNT_W'(BURST_LEN - 1));
        end else if (state_q == GNT_DC) begin
            own_req    = dc_req;
            burst_done = mem_ready && ((beat_cnt_q == CNT_W'(BURST_LEN - 1)) || dc_we);
        end
    end

    // Next-state: arbitration in IDLE, release on completion or abort
    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        last_dc_d  = last_dc_q;
        case (state_q)
            IDLE: begin
                if (ic_req && dc_req) begin
                    state_d = ((DC_PRIORITY != 0) || !last_dc_q) ? GNT_DC : GNT_IC;
                end else if (ic_req) begin
                    state_d = GNT_IC;
                end else if (dc_req) begin
                    state_d = GNT_DC;
                end
            end
            GNT_IC, GNT_DC: begin
                if (!own_req || burst_done) begin
                    state_d    = IDLE;
                    beat_cnt_d = '0;
                    last_dc_d  = (state_q == GNT_DC);
                end else if (mem_ready) begin
                    beat_cnt_d = beat_cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d    = IDLE;
                beat_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            beat_cnt_q <= '0;
            last_dc_q  <= 1'b1;
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
            last_dc_q  <= last_dc_d;
        end
    end

    // Memory-port mux follows the registered owner; aborting owner gets no ready
    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        ic_ready  = 1'b0;
        dc_ready  = 1'b0;
        case (state_q)
            GNT_IC: begin
                mem_req  = ic_req;
                mem_addr = ic_addr;
                ic_ready = ic_req && mem_ready;
            end
            GNT_DC: begin
                mem_req   = dc_req;
                mem_we    = dc_we;
                mem_addr  = dc_addr;
                mem_wdata = dc_wdata;
                dc_ready  = dc_req && mem_ready;
            end
            default: begin
                mem_req = 1'b0;
            end
        endcase
    end

    assign grant_ic = (state_q == GNT_IC);
    assign grant_dc = (state_q == GNT_DC);
    assign ic_rdata = mem_rdata;
    assign dc_rdata = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: randomized round-robin traffic with scoreboard, plus a directed
// dcache-priority instance covering priority ties, async reset mid-burst and a single write.
module tb_mem_arbiter;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } dc_exp_t;

    function automatic logic [31:0] rd_of(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_A5A5;
    endfunction

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b want %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got no completion want completion at %0t", name, $time);
    endtask

    // ---------------- round-robin DUT ----------------
    logic        rst;
    logic        ic_req, dc_req, dc_we, mem_ready;
    logic [31:0] ic_addr, dc_addr, dc_wdata, mem_rdata;
    logic [31:0] ic_rdata, dc_rdata, mem_addr, mem_wdata;
    logic        ic_ready, dc_ready, mem_req, mem_we, grant_ic, grant_dc;

    assign mem_rdata = rd_of(mem_addr);

    mem_arbiter #(.BURST_LEN(4), .DC_PRIORITY(0)) u_rr (
        .clk(clk), .rst(rst),
        .ic_req(ic_req), .ic_addr(ic_addr), .ic_rdata(ic_rdata), .ic_ready(ic_ready),
        .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
        .dc_rdata(dc_rdata), .dc_ready(dc_ready),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .grant_ic(grant_ic), .grant_dc(grant_dc)
    );

    // ---------------- dcache-priority DUT ----------------
    logic        rst_p;
    logic        p_ic_req, p_dc_req, p_dc_we, p_mem_ready;
    logic [31:0] p_ic_addr, p_dc_addr, p_dc_wdata;
    logic [31:0] p_mem_rdata = 32'h1234_5678;
    logic [31:0] p_ic_rdata, p_dc_rdata, p_mem_addr, p_mem_wdata;
    logic        p_ic_ready, p_dc_ready, p_mem_req, p_mem_we, p_grant_ic, p_grant_dc;

    mem_arbiter #(.BURST_LEN(4), .DC_PRIORITY(1)) u_pr (
        .clk(clk), .rst(rst_p),
        .ic_req(p_ic_req), .ic_addr(p_ic_addr), .ic_rdata(p_ic_rdata), .ic_ready(p_ic_ready),
        .dc_req(p_dc_req), .dc_we(p_dc_we), .dc_addr(p_dc_addr), .dc_wdata(p_dc_wdata),
        .dc_rdata(p_dc_rdata), .dc_ready(p_dc_ready),
        .mem_req(p_mem_req), .mem_we(p_mem_we), .mem_addr(p_mem_addr), .mem_wdata(p_mem_wdata),
        .mem_rdata(p_mem_rdata), .mem_ready(p_mem_ready),
        .grant_ic(p_grant_ic), .grant_dc(p_grant_dc)
    );

    // ---------------- shared control ----------------
    logic [31:0] ic_exp[$];
    dc_exp_t     dc_exp[$];
    bit go = 0, stop = 0, mon_en = 0;
    bit ic_done = 0, dc_done = 0, prio_done = 0;
    int ready_mode = 0;
    int ic_tx = 0, dc_tx = 0, dc_wr_tx = 0;

    // Memory handshake: always ready, then 1-in-3, then random
    initial begin : mem_model
        int ph;
        ph = 0;
        mem_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            ph = (ph + 1) % 3;
            case (ready_mode)
                0:       mem_ready = 1'b1;
                1:       mem_ready = (ph == 0);
                default: mem_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    initial begin : ic_agent
        logic [31:0] base;
        int beats, abort_at, gap, cyc;
        logic got;
        bit first;
        ic_req = 1'b0; ic_addr = '0; first = 1; got = 1'b0;
        wait (go);
        while (!stop) begin
            gap = first ? 0 : $urandom_range(0, 2);
            first = 0;
            if (gap != 0) begin
                ic_req = 1'b0;
                repeat (gap) begin @(posedge clk); #1; end
            end
            base = {20'h0, 8'($urandom_range(0, 255)), 4'h0};
            abort_at = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 4;
            for (int i = 0; i < 4; i++) ic_exp.push_back(base + 32'(4 * i));
            ic_req = 1'b1; ic_addr = base; beats = 0; cyc = 0;
            while (beats < 4) begin
                if (beats == abort_at || cyc > 400) begin
                    if (cyc > 400) fail_now("ic_burst_timeout");
                    for (int i = beats; i < 4; i++) void'(ic_exp.pop_back());
                    ic_req = 1'b0;
                    @(posedge clk); #1;
                    break;
                end
                @(negedge clk); got = ic_ready;
                @(posedge clk); #1; cyc++;
                if (got) begin
                    beats++;
                    ic_addr = base + 32'(4 * beats);
                end
            end
            if (beats == 4) ic_tx++;
        end
        ic_req = 1'b0;
        ic_done = 1;
    end

    initial begin : dc_agent
        logic [31:0] base, wd;
        int beats, nbeats, abort_at, gap, cyc;
        logic got, we;
        bit first;
        dc_exp_t e;
        dc_req = 1'b0; dc_we = 1'b0; dc_addr = '0; dc_wdata = '0; first = 1; got = 1'b0;
        wait (go);
        while (!stop) begin
            gap = first ? 0 : $urandom_range(0, 2);
            first = 0;
            if (gap != 0) begin
                dc_req = 1'b0;
                repeat (gap) begin @(posedge clk); #1; end
            end
            base = {16'h0, 4'h2, 8'($urandom_range(0, 255)), 4'h0};
            we = 1'($urandom_range(0, 2) == 0);
            wd = $urandom;
            nbeats = we ? 1 : 4;
            abort_at = (!we && $urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : nbeats;
            for (int i = 0; i < nbeats; i++) begin
                e.we = we;
                e.addr = base + 32'(4 * i);
                e.data = we ? wd : rd_of(base + 32'(4 * i));
                dc_exp.push_back(e);
            end
            dc_req = 1'b1; dc_we = we; dc_addr = base; dc_wdata = wd; beats = 0; cyc = 0;
            while (beats < nbeats) begin
                if (beats == abort_at || cyc > 400) begin
                    if (cyc > 400) fail_now("dc_burst_timeout");
                    for (int i = beats; i < nbeats; i++) void'(dc_exp.pop_back());
                    dc_req = 1'b0;
                    @(posedge clk); #1;
                    break;
                end
                @(negedge clk); got = dc_ready;
                @(posedge clk); #1; cyc++;
                if (got) begin
                    beats++;
                    dc_addr = base + 32'(4 * beats);
                end
            end
            if (beats == nbeats) begin
                dc_tx++;
                if (we) dc_wr_tx++;
            end
        end
        dc_req = 1'b0; dc_we = 1'b0;
        dc_done = 1;
    end

    // Reference model of ownership (rules over observed requests/handshakes) and scoreboard
    int m_owner = 0;  // 0 none, 1 icache, 2 dcache
    int m_last  = 2;
    int m_beats = 0;

    always @(negedge clk) begin : monitor
        logic own_req, exp_icr, exp_dcr;
        dc_exp_t e;
        if (!rst && mon_en) begin
            chk1("grant_ic", grant_ic, m_owner == 1);
            chk1("grant_dc", grant_dc, m_owner == 2);
            chk32("ic_rdata_bcast", ic_rdata, mem_rdata);
            chk32("dc_rdata_bcast", dc_rdata, mem_rdata);
            case (m_owner)
                0: begin
                    chk1("idle_mem_req", mem_req, 1'b0);
                    chk1("idle_mem_we", mem_we, 1'b0);
                    chk32("idle_mem_addr", mem_addr, 32'h0);
                    chk32("idle_mem_wdata", mem_wdata, 32'h0);
                end
                1: begin
                    chk1("ic_mem_req", mem_req, ic_req);
                    chk1("ic_mem_we", mem_we, 1'b0);
                    chk32("ic_mem_addr", mem_addr, ic_addr);
                end
                default: begin
                    chk1("dc_mem_req", mem_req, dc_req);
                    chk1("dc_mem_we", mem_we, dc_we);
                    chk32("dc_mem_addr", mem_addr, dc_addr);
                    chk32("dc_mem_wdata", mem_wdata, dc_wdata);
                end
            endcase
            exp_icr = (m_owner == 1) && ic_req && mem_ready;
            exp_dcr = (m_owner == 2) && dc_req && mem_ready;
            chk1("ic_ready", ic_ready, exp_icr);
            chk1("dc_ready", dc_ready, exp_dcr);
            if (ic_ready && exp_icr) begin
                chk1("ic_beat_expected", ic_exp.size() != 0, 1'b1);
                if (ic_exp.size() != 0) begin
                    chk32("ic_beat_addr", mem_addr, ic_exp[0]);
                    chk32("ic_beat_data", ic_rdata, rd_of(ic_exp[0]));
                    void'(ic_exp.pop_front());
                end
            end
            if (dc_ready && exp_dcr) begin
                chk1("dc_beat_expected", dc_exp.size() != 0, 1'b1);
                if (dc_exp.size() != 0) begin
                    e = dc_exp.pop_front();
                    chk1("dc_beat_we", mem_we, e.we);
                    chk32("dc_beat_addr", mem_addr, e.addr);
                    if (e.we) chk32("dc_beat_wdata", mem_wdata, e.data);
                    else      chk32("dc_beat_rdata", dc_rdata, e.data);
                end
            end
            if (m_owner == 0) begin
                if (ic_req && dc_req) m_owner = (m_last == 1) ? 2 : 1;
                else if (ic_req)      m_owner = 1;
                else if (dc_req)      m_owner = 2;
            end else begin
                own_req = (m_owner == 1) ? ic_req : dc_req;
                if (!own_req || (mem_ready && (m_beats + 1 == 4 || (m_owner == 2 && dc_we)))) begin
                    m_last  = m_owner;
                    m_owner = 0;
                    m_beats = 0;
                end else if (mem_ready) begin
                    m_beats++;
                end
            end
        end
    end

    // Directed sequence on the dcache-priority instance
    initial begin : prio_seq
        p_ic_req = 1'b0; p_dc_req = 1'b0; p_dc_we = 1'b0; p_mem_ready = 1'b1;
        p_ic_addr = 32'h100; p_dc_addr = 32'h3000; p_dc_wdata = 32'h0; rst_p = 1'b1;
        repeat (2) @(posedge clk); #1;
        rst_p = 1'b0; p_ic_req = 1'b1; p_dc_req = 1'b1;
        for (int c = 0; c < 13; c++) begin
            @(negedge clk);
            chk1("p_tie_grant_dc", p_grant_dc, (c % 5) != 0);
            chk1("p_tie_grant_ic", p_grant_ic, 1'b0);
        end
        #2 rst_p = 1'b1;
        #1;
        chk1("p_rst_mem_req", p_mem_req, 1'b0);
        chk1("p_rst_mem_we", p_mem_we, 1'b0);
        chk32("p_rst_mem_addr", p_mem_addr, 32'h0);
        chk32("p_rst_mem_wdata", p_mem_wdata, 32'h0);
        chk1("p_rst_ic_ready", p_ic_ready, 1'b0);
        chk1("p_rst_dc_ready", p_dc_ready, 1'b0);
        chk1("p_rst_grant_ic", p_grant_ic, 1'b0);
        chk1("p_rst_grant_dc", p_grant_dc, 1'b0);
        @(posedge clk); #1;
        rst_p = 1'b0; p_dc_req = 1'b0;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            chk1("p_ic_grant", p_grant_ic, k >= 1 && k <= 4);
            chk1("p_ic_ready", p_ic_ready, k >= 1 && k <= 4);
            chk1("p_ic_dc_ready", p_dc_ready, 1'b0);
            if (k >= 1 && k <= 4) begin
                chk32("p_ic_addr", p_mem_addr, 32'h100 + 32'(4 * (k - 1)));
                chk32("p_ic_rdata", p_ic_rdata, 32'h1234_5678);
            end
            @(posedge clk); #1;
            if (k >= 1 && k <= 4) p_ic_addr = p_ic_addr + 32'd4;
            if (k == 4) p_ic_req = 1'b0;
        end
        p_dc_req = 1'b1; p_dc_we = 1'b1; p_dc_addr = 32'h2000; p_dc_wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        chk1("p_wr_idle", p_grant_dc, 1'b0);
        @(posedge clk); #1;
        @(negedge clk);
        chk1("p_wr_grant", p_grant_dc, 1'b1);
        chk1("p_wr_mem_we", p_mem_we, 1'b1);
        chk32("p_wr_addr", p_mem_addr, 32'h2000);
        chk32("p_wr_data", p_mem_wdata, 32'hDEAD_BEEF);
        chk1("p_wr_ready", p_dc_ready, 1'b1);
        chk32("p_dc_rdata_bcast", p_dc_rdata, 32'h1234_5678);
        @(posedge clk); #1;
        p_dc_req = 1'b0; p_dc_we = 1'b0;
        @(negedge clk);
        chk1("p_wr_release", p_grant_dc, 1'b0);
        chk1("p_wr_no_ready", p_dc_ready, 1'b0);
        prio_done = 1;
    end

    initial begin : main
        int i;
        rst = 1'b1;
        repeat (2) @(posedge clk); #1;
        chk1("rst_mem_req", mem_req, 1'b0);
        chk1("rst_mem_we", mem_we, 1'b0);
        chk32("rst_mem_addr", mem_addr, 32'h0);
        chk32("rst_mem_wdata", mem_wdata, 32'h0);
        chk1("rst_ic_ready", ic_ready, 1'b0);
        chk1("rst_dc_ready", dc_ready, 1'b0);
        chk1("rst_grant_ic", grant_ic, 1'b0);
        chk1("rst_grant_dc", grant_dc, 1'b0);
        rst = 1'b0; go = 1; mon_en = 1;
        repeat (800)  @(posedge clk);
        ready_mode = 1;
        repeat (1200) @(posedge clk);
        ready_mode = 2;
        repeat (1200) @(posedge clk);
        stop = 1;
        i = 0;
        while (!(ic_done && dc_done && prio_done) && i < 3000) begin
            @(posedge clk);
            i++;
        end
        chk1("agents_drained", ic_done && dc_done && prio_done, 1'b1);
        repeat (3) @(posedge clk);
        chk32("ic_queue_empty", 32'(ic_exp.size()), 32'h0);
        chk32("dc_queue_empty", 32'(dc_exp.size()), 32'h0);
        chk1("ic_bursts_served", ic_tx > 5, 1'b1);
        chk1("dc_bursts_served", dc_tx > 5, 1'b1);
        chk1("dc_writes_served", dc_wr_tx > 0, 1'b1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
